// File: rtl/fetch_unit.sv
// fetch_unit: owns the architectural PC, fetches instruction words over a
// req/gnt/rvalid memory port and hands them to decode under valid/ready.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   next_pc                 next-PC target, taken when decode accepts
//   flush, flush_pc         redirect (highest priority) and its target
//   imem_req/addr           fetch request and address (address == cur_pc)
//   imem_gnt                request accepted by memory this cycle
//   imem_rvalid/rdata       response strobe and instruction word
//   inst_valid, inst_ready  decode handshake
//   instr, cur_pc, pc4      presented instruction, its PC, and PC + 4
//   misalign                sticky flag: a loaded target had nonzero [1:0]
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instr,
    output logic [31:0] cur_pc,
    output logic [31:0] pc4,
    output logic        misalign
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = 2;

    localparam logic [SW-1:0] FETCH = 2'd0;
    localparam logic [SW-1:0] WAIT  = 2'd1;
    localparam logic [SW-1:0] HOLD  = 2'd2;
    localparam logic [SW-1:0] DROP  = 2'd3;

    logic [SW-1:0]   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            misalign_q, misalign_d;

    // Next-state and datapath update; flush overrides every handshake.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;

        if (flush) begin
            pc_d       = {flush_pc[XLEN-1:2], 2'b00};
            misalign_d = misalign_q | (flush_pc[1:0] != 2'b00);
            case (state_q)
                // A grant in the flush cycle leaves a response we must drop.
                FETCH:   state_d = imem_gnt ? DROP : FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH : DROP;
                HOLD:    state_d = FETCH;
                // The outstanding response may land in the flush cycle itself;
                // once it has, nothing is left to drop.
                DROP:    state_d = imem_rvalid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc_d       = {next_pc[XLEN-1:2], 2'b00};
                        misalign_d = misalign_q | (next_pc[1:0] != 2'b00);
                        state_d    = FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs are direct decodes of registered state.
    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == HOLD);
    assign instr      = instr_q;
    assign cur_pc     = pc_q;
    assign pc4        = pc_q + XLEN'(4);
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level model (outstanding-response
// queue, "instruction held" flag, PC) plus a memory responder with random
// latency, compared against the DUT every cycle, and directed scenarios
// with literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_pc = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] cur_pc;
    logic [31:0] pc4;
    logic        misalign;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .flush(flush),
        .flush_pc(flush_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instr(instr),
        .cur_pc(cur_pc), .pc4(pc4), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: PC, last accepted word, whether an instruction is held for
    // decode, sticky misalign, and tags of responses still owed by memory
    // (1 = wanted, 0 = to be thrown away).
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = '0;
    bit          m_have = 1'b0;
    bit          m_mis = 1'b0;
    bit          pend[$];

    // Memory responder state.
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 0;
    logic [31:0] mem_data = '0;
    bit          spur_en = 1'b0;

    // Grant log: cycle number (1 = first cycle after reset) and address.
    int          cyc = 0;
    int          gl_cyc[$];
    logic [31:0] gl_addr[$];

    bit          mreq, mresp, macc, mtag;
    logic [31:0] maddr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge, from the inputs the DUT also sees.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_pc = RST_PC; m_instr = '0; m_have = 1'b0; m_mis = 1'b0;
                pend.delete(); mem_busy = 1'b0; mem_cnt = 0; cyc = 0;
            end else begin
                cyc++;
                maddr = m_pc;
                mreq  = (pend.size() == 0) && !m_have;
                mresp = imem_rvalid && (pend.size() != 0);
                macc  = m_have && inst_ready && !flush;
                if (mresp) begin
                    mtag = pend.pop_front();
                    mem_busy = 1'b0;
                    if (mtag && !flush) begin
                        m_instr = imem_rdata;
                        m_have  = 1'b1;
                    end
                end else if (mem_busy && mem_cnt != 0) begin
                    mem_cnt--;
                end
                if (flush) begin
                    m_pc   = flush_pc & 32'hFFFF_FFFC;
                    m_mis  = m_mis | (flush_pc[1:0] != 2'b00);
                    m_have = 1'b0;
                    foreach (pend[i]) pend[i] = 1'b0;
                end else if (macc) begin
                    m_pc   = next_pc & 32'hFFFF_FFFC;
                    m_mis  = m_mis | (next_pc[1:0] != 2'b00);
                    m_have = 1'b0;
                end
                if (mreq && imem_gnt) begin
                    gl_cyc.push_back(cyc);
                    gl_addr.push_back(maddr);
                    pend.push_back(!flush);
                    mem_busy = 1'b1;
                    mem_cnt  = mem_lat;
                    mem_data = $urandom;
                end
            end
        end
    end

    // Memory response driver, plus optional stray rvalid while idle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_busy && mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data;
            end else begin
                imem_rvalid = spur_en && !mem_busy && ($urandom_range(0, 7) == 0);
                imem_rdata  = $urandom;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("imem_req",   32'(imem_req),   32'((pend.size() == 0) && !m_have));
                check("imem_addr",  imem_addr,       m_pc);
                check("cur_pc",     cur_pc,          m_pc);
                check("pc4",        pc4,             m_pc + 32'd4);
                check("inst_valid", 32'(inst_valid), 32'(m_have));
                check("instr",      instr,           m_instr);
                check("misalign",   32'(misalign),   32'(m_mis));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit cond(input int k);
        if (k == 0) return m_have;
        return pend.size() != 0;
    endfunction

    task automatic wait_for(input int k, input string name);
        for (int i = 0; i < 30 && !cond(k); i++) tick();
        check(name, 32'(cond(k)), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; inst_ready = 1'b0; imem_gnt = 1'b0;
        tick();
        tick();
        check("rst_valid",    32'(inst_valid), 32'd0);
        check("rst_pc",       cur_pc,          32'h0000_3000);
        check("rst_instr",    instr,           32'd0);
        check("rst_misalign", 32'(misalign),   32'd0);
        reset = 1'b0;
    endtask

    int          n0;
    bit          seen;
    logic [31:0] held;

    initial begin
        tick();
        do_reset();

        // Back-to-back fetch: grants on cycles 1, 4, 7 at sequential PCs.
        imem_gnt = 1'b1; inst_ready = 1'b1; mem_lat = 0;
        repeat (9) begin
            next_pc = m_pc + 32'd4;
            tick();
        end
        check("t1_ngrants", 32'(gl_cyc.size() >= 3), 32'd1);
        if (gl_cyc.size() >= 3) begin
            check("t1_cyc0",  32'(gl_cyc[0]), 32'd1);
            check("t1_cyc1",  32'(gl_cyc[1]), 32'd4);
            check("t1_cyc2",  32'(gl_cyc[2]), 32'd7);
            check("t1_addr0", gl_addr[0], 32'h0000_3000);
            check("t1_addr1", gl_addr[1], 32'h0000_3004);
            check("t1_addr2", gl_addr[2], 32'h0000_3008);
        end

        // Decode stalls for 5 cycles in HOLD.
        do_reset();
        imem_gnt = 1'b1; inst_ready = 1'b0; mem_lat = 0;
        wait_for(0, "t2_wait_hold");
        held = m_instr;
        repeat (5) begin
            tick();
            check("t2_valid", 32'(inst_valid), 32'd1);
            check("t2_pc",    cur_pc,          32'h0000_3000);
            check("t2_instr", instr,           held);
        end
        next_pc = 32'h0000_3040; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t2_req",  32'(imem_req), 32'd1);
        check("t2_addr", imem_addr,     32'h0000_3040);

        // Grant withheld for 3 cycles.
        imem_gnt = 1'b0;
        n0 = gl_cyc.size();
        repeat (3) begin
            tick();
            check("t3_req",   32'(imem_req),   32'd1);
            check("t3_addr",  imem_addr,       32'h0000_3040);
            check("t3_valid", 32'(inst_valid), 32'd0);
        end
        check("t3_nogrant", 32'(gl_cyc.size()), 32'(n0));

        // Flush in WAIT; the response lands 2 cycles later and is dropped.
        imem_gnt = 1'b1; mem_lat = 2;
        wait_for(1, "t4_wait_wait");
        flush = 1'b1; flush_pc = 32'h0000_4180;
        n0 = gl_cyc.size();
        tick();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && gl_cyc.size() == n0; i++) begin
            if (inst_valid) seen = 1'b1;
            tick();
        end
        check("t4_no_valid", 32'(seen), 32'd0);
        check("t4_regrant",  32'(gl_cyc.size() > n0), 32'd1);
        if (gl_cyc.size() > n0) check("t4_addr", gl_addr[n0], 32'h0000_4180);

        // Flush coincident with rvalid in WAIT.
        do_reset();
        imem_gnt = 1'b1; inst_ready = 1'b1; mem_lat = 0;
        wait_for(0, "t5_first_hold");
        tick();
        wait_for(1, "t5_wait_wait");
        held = m_instr;
        flush = 1'b1; flush_pc = 32'h0000_5000;
        tick();
        flush = 1'b0;
        check("t5_instr", instr,           held);
        check("t5_valid", 32'(inst_valid), 32'd0);
        check("t5_req",   32'(imem_req),   32'd1);
        check("t5_addr",  imem_addr,       32'h0000_5000);

        // Flush coincident with the decode handshake.
        inst_ready = 1'b0;
        wait_for(0, "t6_wait_hold");
        inst_ready = 1'b1; next_pc = 32'h0000_6000;
        flush = 1'b1; flush_pc = 32'h0000_7000;
        tick();
        flush = 1'b0; inst_ready = 1'b0;
        check("t6_addr",  imem_addr,       32'h0000_7000);
        check("t6_valid", 32'(inst_valid), 32'd0);

        // Misaligned next_pc: aligned load, sticky flag.
        do_reset();
        imem_gnt = 1'b1; inst_ready = 1'b0;
        wait_for(0, "t7_wait_hold");
        check("t7_mis_before", 32'(misalign), 32'd0);
        next_pc = 32'h0000_3006; inst_ready = 1'b1;
        tick();
        check("t7_addr", imem_addr,     32'h0000_3004);
        check("t7_mis",  32'(misalign), 32'd1);
        repeat (10) begin
            next_pc = m_pc + 32'd4;
            tick();
        end
        check("t7_mis_sticky", 32'(misalign), 32'd1);

        // PC wrap.
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        check("t8_pc",  cur_pc, 32'hFFFF_FFFC);
        check("t8_pc4", pc4,    32'h0000_0000);

        // Random traffic.
        do_reset();
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 750 == 749) begin
                do_reset();
            end
            imem_gnt   = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 11) == 0);
            flush_pc   = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            next_pc    = ($urandom_range(0, 1) == 0) ? m_pc + 32'd4
                       : ($urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC));
            mem_lat    = $urandom_range(0, 3);
            tick();
        end
        spur_en = 1'b0;
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
